// File: rtl/lane_controller.sv
// Lane controller: turns sustained joystick tilts into single lane moves and
// runs the IDLE/RUN/OVER game sequence. All outputs are registered.
module lane_controller #(
  parameter int LANES          = 3,
  parameter int START_LANE     = 1,
  parameter int HOLD_CYCLES    = 16,
  parameter int RELEASE_CYCLES = 8
) (
  input  logic       fast_hz,
  input  logic       rst_n,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       start,
  input  logic       crash,
  output logic [1:0] lane,
  output logic [1:0] game_state,
  output logic       playing,
  output logic       move_pulse,
  output logic       bump_pulse
);

  localparam int MAX_CYC = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [1:0]    START_IDX = 2'(START_LANE);
  localparam logic [1:0]    LAST_IDX  = 2'(LANES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_RUN  = 2'd1,
    G_OVER = 2'd2
  } game_t;

  typedef enum logic [1:0] {
    M_ARMED,
    M_HOLD_L,
    M_HOLD_R,
    M_WAIT
  } move_t;

  game_t         gstate, g_nxt;
  move_t         mstate, m_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    lane_nxt;
  logic          move_nxt, bump_nxt;
  logic          start_q;
  logic          tilt_l, tilt_r, neutral, start_rise;
  logic          fire_l, fire_r;

  assign tilt_l     = btn_l & ~btn_r;
  assign tilt_r     = btn_r & ~btn_l;
  assign neutral    = ~(tilt_l | tilt_r);
  assign start_rise = start & ~start_q;
  assign game_state = gstate;

  always_ff @(posedge fast_hz) begin
    if (!rst_n) begin
      gstate     <= G_IDLE;
      mstate     <= M_ARMED;
      cnt        <= '0;
      lane       <= START_IDX;
      start_q    <= 1'b0;
      playing    <= 1'b0;
      move_pulse <= 1'b0;
      bump_pulse <= 1'b0;
    end else begin
      gstate     <= g_nxt;
      mstate     <= m_nxt;
      cnt        <= cnt_nxt;
      lane       <= lane_nxt;
      start_q    <= start;
      playing    <= (g_nxt == G_RUN);
      move_pulse <= move_nxt;
      bump_pulse <= bump_nxt;
    end
  end

  always_comb begin
    g_nxt    = gstate;
    m_nxt    = mstate;
    cnt_nxt  = cnt;
    lane_nxt = lane;
    move_nxt = 1'b0;
    bump_nxt = 1'b0;
    fire_l   = 1'b0;
    fire_r   = 1'b0;

    case (gstate)
      G_IDLE, G_OVER: begin
        if (gstate == G_IDLE) lane_nxt = START_IDX;
        // Starting parks the move FSM in WAIT so a tilt held across start is ignored.
        if (start_rise) begin
          g_nxt    = G_RUN;
          lane_nxt = START_IDX;
          m_nxt    = M_WAIT;
          cnt_nxt  = '0;
        end
      end
      G_RUN: begin
        if (crash) begin
          g_nxt   = G_OVER;
          m_nxt   = M_ARMED;
          cnt_nxt = '0;
        end else begin
          case (mstate)
            M_ARMED: begin
              if (tilt_l) begin
                if (HOLD_CYCLES == 1) fire_l = 1'b1;
                else begin m_nxt = M_HOLD_L; cnt_nxt = CNT_ONE; end
              end else if (tilt_r) begin
                if (HOLD_CYCLES == 1) fire_r = 1'b1;
                else begin m_nxt = M_HOLD_R; cnt_nxt = CNT_ONE; end
              end
            end
            M_HOLD_L: begin
              if (!tilt_l) begin m_nxt = M_ARMED; cnt_nxt = '0; end
              else if (cnt == HOLD_LAST) fire_l = 1'b1;
              else cnt_nxt = cnt + CNT_ONE;
            end
            M_HOLD_R: begin
              if (!tilt_r) begin m_nxt = M_ARMED; cnt_nxt = '0; end
              else if (cnt == HOLD_LAST) fire_r = 1'b1;
              else cnt_nxt = cnt + CNT_ONE;
            end
            default: begin
              if (!neutral) cnt_nxt = '0;
              else if (cnt == REL_LAST) begin m_nxt = M_ARMED; cnt_nxt = '0; end
              else cnt_nxt = cnt + CNT_ONE;
            end
          endcase

          // A qualified move at the edge lane becomes a bump instead of wrapping.
          if (fire_l || fire_r) begin
            m_nxt   = M_WAIT;
            cnt_nxt = '0;
            if (fire_l) begin
              if (lane == 2'd0) bump_nxt = 1'b1;
              else begin lane_nxt = lane - 2'd1; move_nxt = 1'b1; end
            end else begin
              if (lane == LAST_IDX) bump_nxt = 1'b1;
              else begin lane_nxt = lane + 2'd1; move_nxt = 1'b1; end
            end
          end
        end
      end
      default: begin
        g_nxt   = G_IDLE;
        m_nxt   = M_ARMED;
        cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_lane_controller.sv
// Directed bench for lane_controller with HOLD_CYCLES=4, RELEASE_CYCLES=2.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_lane_controller;

  logic       fast_hz = 1'b0;
  logic       rst_n;
  logic       btn_l, btn_r, start, crash;
  logic [1:0] lane, game_state;
  logic       playing, move_pulse, bump_pulse;

  int checks_total  = 0;
  int checks_failed = 0;
  int move_seen     = 0;
  int bump_seen     = 0;

  lane_controller #(
    .LANES(3), .START_LANE(1), .HOLD_CYCLES(4), .RELEASE_CYCLES(2)
  ) dut (
    .fast_hz   (fast_hz),
    .rst_n     (rst_n),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .start     (start),
    .crash     (crash),
    .lane      (lane),
    .game_state(game_state),
    .playing   (playing),
    .move_pulse(move_pulse),
    .bump_pulse(bump_pulse)
  );

  always #5 fast_hz = ~fast_hz;

  task automatic applyStimulus(input logic l, input logic r, input logic s, input logic c);
    btn_l = l;
    btn_r = r;
    start = s;
    crash = c;
  endtask

  // Advance n rising edges, tallying every pulse seen so missed or extra strobes show up.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge fast_hz);
      if (move_pulse === 1'b1) move_seen++;
      if (bump_pulse === 1'b1) bump_seen++;
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks_total++;
    assert (observed === expected)
    else begin
      checks_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int exp_lane, input int exp_gs,
                          input int exp_move, input int exp_bump);
    checkOutput({tag, "_lane"}, int'(lane), exp_lane);
    checkOutput({tag, "_state"}, int'(game_state), exp_gs);
    checkOutput({tag, "_playing"}, int'(playing), (exp_gs == 1) ? 1 : 0);
    checkOutput({tag, "_move"}, int'(move_pulse), exp_move);
    checkOutput({tag, "_bump"}, int'(bump_pulse), exp_bump);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    step(2);
    checkAll("reset", 1, 0, 0, 0);
    rst_n = 1'b1;

    $display("[TB] test 1: tilts ignored in IDLE");
    applyStimulus(1, 0, 0, 0);
    step(10);
    checkAll("idle_tilt", 1, 0, 0, 0);

    $display("[TB] test 2: start and first left move");
    applyStimulus(0, 0, 0, 0);
    step(1);
    applyStimulus(0, 0, 1, 0);
    step(1);
    checkAll("start_run", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    step(2);
    applyStimulus(1, 0, 0, 0);
    step(3);
    checkAll("hold3", 1, 1, 0, 0);
    step(1);
    checkAll("hold4_move", 0, 1, 1, 0);
    step(1);
    checkAll("pulse_end", 0, 1, 0, 0);
    step(19);
    checkAll("no_repeat", 0, 1, 0, 0);
    checkOutput("move_count_t2", move_seen, 1);

    $display("[TB] test 3: short hold and both buttons");
    applyStimulus(0, 0, 0, 0);
    step(2);
    applyStimulus(1, 0, 0, 0);
    step(3);
    applyStimulus(0, 0, 0, 0);
    step(1);
    applyStimulus(1, 1, 0, 0);
    step(10);
    checkAll("both_high", 0, 1, 0, 0);
    checkOutput("bump_count_t3", bump_seen, 0);
    checkOutput("move_count_t3", move_seen, 1);

    $display("[TB] test 4: edge bumps and re-arm");
    applyStimulus(0, 0, 0, 0);
    step(2);
    applyStimulus(1, 0, 0, 0);
    step(4);
    checkAll("bump_left", 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0);
    step(1);
    applyStimulus(0, 1, 0, 0);
    step(4);
    checkAll("short_release", 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    step(2);
    applyStimulus(0, 1, 0, 0);
    step(4);
    checkAll("right_to1", 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    step(2);
    applyStimulus(0, 1, 0, 0);
    step(4);
    checkAll("right_to2", 2, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    step(2);
    applyStimulus(0, 1, 0, 0);
    step(4);
    checkAll("bump_right", 2, 1, 0, 1);
    checkOutput("move_count_t4", move_seen, 3);
    checkOutput("bump_count_t4", bump_seen, 2);

    $display("[TB] test 5: crash and restart");
    applyStimulus(0, 0, 0, 0);
    step(2);
    applyStimulus(1, 0, 0, 0);
    step(3);
    applyStimulus(1, 0, 0, 1);
    step(1);
    checkAll("crash", 2, 2, 0, 0);
    applyStimulus(1, 0, 0, 0);
    step(5);
    checkAll("over_frozen", 2, 2, 0, 0);
    applyStimulus(0, 1, 1, 0);
    step(1);
    checkAll("restart", 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    step(10);
    checkAll("held_across", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    step(1);
    applyStimulus(0, 1, 0, 0);
    step(4);
    checkAll("one_neutral", 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    step(2);
    applyStimulus(0, 1, 0, 0);
    step(4);
    checkAll("rearmed_move", 2, 1, 1, 0);
    checkOutput("move_count_t5", move_seen, 4);
    checkOutput("bump_count_t5", bump_seen, 2);

    $display("[TB] test 6: reset mid-hold");
    applyStimulus(0, 0, 0, 0);
    step(2);
    applyStimulus(0, 1, 0, 0);
    step(2);
    rst_n = 1'b0;
    step(1);
    checkAll("reset_mid", 1, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0);
    step(4);
    checkAll("post_reset", 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    step(1);
    checkAll("start_after_rst", 1, 1, 0, 0);
    checkOutput("move_count_end", move_seen, 4);

    $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
    $finish;
  end

endmodule
